// File: rtl/hazard_unit_if.sv
// ---------------------------------------------------------------------------
// hazard_unit_if
// Bundles the pipeline-status inputs and the latch-control/status outputs of
// the hazard unit so the core and the hazard unit connect through one port.
//
// Signals (direction as seen by the hazard unit):
//   ihit, dhit            in   cache handshakes for this cycle
//   mem_dREN, mem_dWEN    in   MEM-stage load / store
//   mem_br_taken          in   branch/jump resolved taken in MEM
//   ex_MemRead, ex_rt     in   EX-stage load and its destination register
//   id_rs, id_rt          in   ID-stage source registers
//   wb_halt               in   halt instruction reached WB
//   pc_en, *_en, *_flush  out  PC enable and pipeline latch enables/bubbles
//   halt                  out  sticky halt
//   stall_cycles          out  saturating count of PC-frozen cycles
//   flush_count           out  saturating count of taken-branch flushes
//   dmiss_timeout         out  sticky D-miss watchdog flag
//
// Modports: master is the pipeline side that reports status and consumes the
// controls; slave is the hazard unit itself.
// ---------------------------------------------------------------------------
interface hazard_unit_if #(
   parameter int CNT_W = 16
);
   logic             ihit;
   logic             dhit;
   logic             mem_dREN;
   logic             mem_dWEN;
   logic             mem_br_taken;
   logic             ex_MemRead;
   logic [4:0]       ex_rt;
   logic [4:0]       id_rs;
   logic [4:0]       id_rt;
   logic             wb_halt;

   logic             pc_en;
   logic             ifid_en;
   logic             ifid_flush;
   logic             idex_en;
   logic             idex_flush;
   logic             exmem_en;
   logic             exmem_flush;
   logic             memwb_en;
   logic             memwb_flush;
   logic             halt;
   logic [CNT_W-1:0] stall_cycles;
   logic [CNT_W-1:0] flush_count;
   logic             dmiss_timeout;

   modport master (
      output ihit, dhit, mem_dREN, mem_dWEN, mem_br_taken,
             ex_MemRead, ex_rt, id_rs, id_rt, wb_halt,
      input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
             exmem_en, exmem_flush, memwb_en, memwb_flush,
             halt, stall_cycles, flush_count, dmiss_timeout
   );

   modport slave (
      input  ihit, dhit, mem_dREN, mem_dWEN, mem_br_taken,
             ex_MemRead, ex_rt, id_rs, id_rt, wb_halt,
      output pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
             exmem_en, exmem_flush, memwb_en, memwb_flush,
             halt, stall_cycles, flush_count, dmiss_timeout
   );
endinterface

// File: rtl/hazard_unit.sv
// ---------------------------------------------------------------------------
// hazard_unit
// Pipeline control for the 5-stage MIPS core. Produces the PC enable and the
// IF/ID, ID/EX, EX/MEM, MEM/WB latch enables and bubble inserts, resolving
// (highest priority first) halt, D-cache miss stalls, taken-branch flushes,
// load-use bubbles and I-cache miss bubbles. Also keeps saturating
// stall/flush statistics and a sticky D-miss watchdog.
//
// Parameters:
//   CNT_W    width of stall_cycles / flush_count (saturating)
//   TIMEOUT  consecutive D-miss cycles before dmiss_timeout sets
//
// Ports:
//   CLK   clock, rising edge
//   RST   synchronous active-high reset
//   hif   hazard_unit_if.slave (status in, controls/statistics out)
// ---------------------------------------------------------------------------
module hazard_unit #(
   parameter int CNT_W   = 16,
   parameter int TIMEOUT = 64
) (
   input  logic           CLK,
   input  logic           RST,
   hazard_unit_if.slave   hif
);

   localparam int MISS_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {RUN, DSTALL, HALTED} state_t;

   state_t             state_q, state_d;
   logic               halt_q, halt_d;
   logic [CNT_W-1:0]   stall_cycles_q, stall_cycles_d;
   logic [CNT_W-1:0]   flush_count_q, flush_count_d;
   logic [MISS_W-1:0]  miss_cnt_q, miss_cnt_d;
   logic               dmiss_timeout_q, dmiss_timeout_d;

   logic dstall;
   logic lu;
   logic pc_en_c, ifid_en_c, ifid_flush_c, idex_en_c, idex_flush_c;
   logic exmem_en_c, exmem_flush_c, memwb_en_c, memwb_flush_c;

   // A load and a store in the same MEM slot are one access, so a plain OR.
   assign dstall = (hif.mem_dREN | hif.mem_dWEN) & ~hif.dhit;

   // Register 0 is hard-wired to zero, so a load into it never creates a hazard.
   assign lu = hif.ex_MemRead & (hif.ex_rt != 5'd0) &
               ((hif.ex_rt == hif.id_rs) | (hif.ex_rt == hif.id_rt));

   // Latch controls. A flushed latch keeps its enable high so the bubble is
   // actually loaded. Everything is held off during reset and once halted.
   always_comb begin
      pc_en_c       = 1'b0;
      ifid_en_c     = 1'b0;
      ifid_flush_c  = 1'b0;
      idex_en_c     = 1'b0;
      idex_flush_c  = 1'b0;
      exmem_en_c    = 1'b0;
      exmem_flush_c = 1'b0;
      memwb_en_c    = 1'b0;
      memwb_flush_c = 1'b0;
      if (!RST && state_q != HALTED) begin
         if (dstall) begin
            memwb_en_c    = 1'b1;
            memwb_flush_c = 1'b1;
         end else if (hif.mem_br_taken) begin
            pc_en_c       = 1'b1;
            ifid_en_c     = 1'b1;
            idex_en_c     = 1'b1;
            exmem_en_c    = 1'b1;
            memwb_en_c    = 1'b1;
            ifid_flush_c  = 1'b1;
            idex_flush_c  = 1'b1;
            exmem_flush_c = 1'b1;
         end else if (lu) begin
            idex_en_c     = 1'b1;
            idex_flush_c  = 1'b1;
            exmem_en_c    = 1'b1;
            memwb_en_c    = 1'b1;
         end else if (!hif.ihit) begin
            ifid_en_c     = 1'b1;
            ifid_flush_c  = 1'b1;
            idex_en_c     = 1'b1;
            exmem_en_c    = 1'b1;
            memwb_en_c    = 1'b1;
         end else begin
            pc_en_c       = 1'b1;
            ifid_en_c     = 1'b1;
            idex_en_c     = 1'b1;
            exmem_en_c    = 1'b1;
            memwb_en_c    = 1'b1;
         end
      end
   end

   // Next-state logic. The wb_halt cycle itself still runs with the normal
   // priority above; only the following cycle is HALTED. The miss counter
   // restarts at 1 on entry so it counts the entering cycle too.
   always_comb begin
      state_d         = state_q;
      halt_d          = halt_q;
      stall_cycles_d  = stall_cycles_q;
      flush_count_d   = flush_count_q;
      miss_cnt_d      = miss_cnt_q;
      dmiss_timeout_d = dmiss_timeout_q;
      if (state_q != HALTED) begin
         if (hif.wb_halt) begin
            state_d = HALTED;
            halt_d  = 1'b1;
         end else if (dstall) begin
            state_d = DSTALL;
         end else begin
            state_d = RUN;
         end

         if (dstall) begin
            if (state_q == RUN) begin
               miss_cnt_d = MISS_W'(1);
            end else if (miss_cnt_q != MISS_W'(TIMEOUT)) begin
               miss_cnt_d = miss_cnt_q + MISS_W'(1);
            end
            if (miss_cnt_d == MISS_W'(TIMEOUT)) begin
               dmiss_timeout_d = 1'b1;
            end
         end

         if (!pc_en_c && stall_cycles_q != {CNT_W{1'b1}}) begin
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
         end

         if (!dstall && hif.mem_br_taken && flush_count_q != {CNT_W{1'b1}}) begin
            flush_count_d = flush_count_q + CNT_W'(1);
         end
      end
   end

   // All state, including the FSM and its registered status outputs.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q         <= RUN;
         halt_q          <= 1'b0;
         stall_cycles_q  <= '0;
         flush_count_q   <= '0;
         miss_cnt_q      <= '0;
         dmiss_timeout_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         halt_q          <= halt_d;
         stall_cycles_q  <= stall_cycles_d;
         flush_count_q   <= flush_count_d;
         miss_cnt_q      <= miss_cnt_d;
         dmiss_timeout_q <= dmiss_timeout_d;
      end
   end

   assign hif.pc_en         = pc_en_c;
   assign hif.ifid_en       = ifid_en_c;
   assign hif.ifid_flush    = ifid_flush_c;
   assign hif.idex_en       = idex_en_c;
   assign hif.idex_flush    = idex_flush_c;
   assign hif.exmem_en      = exmem_en_c;
   assign hif.exmem_flush   = exmem_flush_c;
   assign hif.memwb_en      = memwb_en_c;
   assign hif.memwb_flush   = memwb_flush_c;
   assign hif.halt          = halt_q;
   assign hif.stall_cycles  = stall_cycles_q;
   assign hif.flush_count   = flush_count_q;
   assign hif.dmiss_timeout = dmiss_timeout_q;

endmodule

// File: tb/tb_hazard_unit.sv
// ---------------------------------------------------------------------------
// tb_hazard_unit
// Directed bench for hazard_unit with CNT_W=4 and TIMEOUT=4. Inputs change on
// the falling edge; each step pushes its expected outputs to a queue and pops
// them just after, well before the next rising edge. Control vectors are
// {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
//  ifid_flush, idex_flush, exmem_flush, memwb_flush}.
// ---------------------------------------------------------------------------
module tb_hazard_unit;

   localparam int CNT_W = 4;

   localparam logic [8:0] C_ZERO  = 9'b00000_0000;
   localparam logic [8:0] C_RUN   = 9'b11111_0000;
   localparam logic [8:0] C_DST   = 9'b00001_0001;
   localparam logic [8:0] C_BR    = 9'b11111_1110;
   localparam logic [8:0] C_LU    = 9'b00111_0100;
   localparam logic [8:0] C_IMISS = 9'b01111_1000;

   typedef struct {
      string             tag;
      logic [8:0]        ctl;
      logic              halt;
      logic [CNT_W-1:0]  sc;
      logic [CNT_W-1:0]  fc;
      logic              to;
   } exp_t;

   logic CLK = 1'b0;
   logic RST;
   int   vectors = 0;
   int   miscompares = 0;
   exp_t sb[$];

   hazard_unit_if #(.CNT_W(CNT_W)) hif ();

   hazard_unit #(.CNT_W(CNT_W), .TIMEOUT(4)) dut (
      .CLK (CLK),
      .RST (RST),
      .hif (hif.slave)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   always #5 CLK = ~CLK;

   // Quiet pipeline: instruction present, no memory access, no hazards.
   task automatic setIdle();
      hif.ihit         = 1'b1;
      hif.dhit         = 1'b0;
      hif.mem_dREN     = 1'b0;
      hif.mem_dWEN     = 1'b0;
      hif.mem_br_taken = 1'b0;
      hif.ex_MemRead   = 1'b0;
      hif.ex_rt        = 5'd0;
      hif.id_rs        = 5'd0;
      hif.id_rt        = 5'd0;
      hif.wb_halt      = 1'b0;
   endtask

   // Queue the outputs expected for the inputs just driven.
   task automatic applyStimulus(input string tag, input logic [8:0] ctl,
                                input logic halt, input int sc, input int fc,
                                input logic to);
      exp_t e;
      e.tag  = tag;
      e.ctl  = ctl;
      e.halt = halt;
      e.sc   = CNT_W'(sc);
      e.fc   = CNT_W'(fc);
      e.to   = to;
      sb.push_back(e);
   endtask

   // Pop the oldest expectation, compare against the DUT, then move to the
   // next falling edge (which passes one rising edge).
   task automatic checkOutput();
      exp_t       e;
      logic [8:0] ctl_obs;
      #1;
      if (sb.size() == 0) begin
         miscompares++;
         $error("FAIL scoreboard empty observed=0 expected=1");
      end else begin
         e = sb.pop_front();
         ctl_obs = {hif.pc_en, hif.ifid_en, hif.idex_en, hif.exmem_en,
                    hif.memwb_en, hif.ifid_flush, hif.idex_flush,
                    hif.exmem_flush, hif.memwb_flush};
         vectors++;
         assert (ctl_obs === e.ctl) else begin
            miscompares++;
            $error("FAIL %s ctl observed=%b expected=%b", e.tag, ctl_obs, e.ctl);
         end
         vectors++;
         assert (hif.halt === e.halt) else begin
            miscompares++;
            $error("FAIL %s halt observed=%b expected=%b", e.tag, hif.halt, e.halt);
         end
         vectors++;
         assert (hif.stall_cycles === e.sc) else begin
            miscompares++;
            $error("FAIL %s stall_cycles observed=%0d expected=%0d", e.tag, hif.stall_cycles, e.sc);
         end
         vectors++;
         assert (hif.flush_count === e.fc) else begin
            miscompares++;
            $error("FAIL %s flush_count observed=%0d expected=%0d", e.tag, hif.flush_count, e.fc);
         end
         vectors++;
         assert (hif.dmiss_timeout === e.to) else begin
            miscompares++;
            $error("FAIL %s dmiss_timeout observed=%b expected=%b", e.tag, hif.dmiss_timeout, e.to);
         end
      end
      @(negedge CLK);
   endtask

   task automatic step(input string tag, input logic [8:0] ctl, input logic halt,
                       input int sc, input int fc, input logic to);
      applyStimulus(tag, ctl, halt, sc, fc, to);
      checkOutput();
   endtask

   // Directed sequence: reset, load-use, D-miss stall, branch flush, watchdog,
   // counter saturation, halt, and reset during halt and during a stall.
   initial begin
      RST = 1'b1;
      setIdle();
      @(negedge CLK);

      step("rst_idle", C_ZERO, 1'b0, 0, 0, 1'b0);
      hif.mem_dREN = 1'b1;
      step("rst_dstall", C_ZERO, 1'b0, 0, 0, 1'b0);

      RST = 1'b0;
      setIdle();
      step("run0", C_RUN, 1'b0, 0, 0, 1'b0);
      step("run1", C_RUN, 1'b0, 0, 0, 1'b0);

      hif.ex_MemRead = 1'b1; hif.ex_rt = 5'd5; hif.id_rs = 5'd5;
      step("lu_rs", C_LU, 1'b0, 0, 0, 1'b0);
      hif.id_rs = 5'd3; hif.id_rt = 5'd5;
      step("lu_rt", C_LU, 1'b0, 1, 0, 1'b0);
      hif.ex_rt = 5'd0; hif.id_rs = 5'd0; hif.id_rt = 5'd0;
      step("lu_r0", C_RUN, 1'b0, 2, 0, 1'b0);
      hif.ex_MemRead = 1'b0; hif.ex_rt = 5'd5; hif.id_rs = 5'd5;
      step("no_load", C_RUN, 1'b0, 2, 0, 1'b0);

      setIdle();
      hif.mem_dREN = 1'b1;
      for (int i = 0; i < 3; i++) step("dstall", C_DST, 1'b0, 2 + i, 0, 1'b0);
      hif.dhit = 1'b1;
      step("dhit_release", C_RUN, 1'b0, 5, 0, 1'b0);
      setIdle();
      step("after_dstall", C_RUN, 1'b0, 5, 0, 1'b0);

      hif.mem_br_taken = 1'b1; hif.ex_MemRead = 1'b1;
      hif.ex_rt = 5'd7; hif.id_rs = 5'd7; hif.ihit = 1'b0;
      step("br_over_lu", C_BR, 1'b0, 5, 0, 1'b0);
      setIdle();
      step("br_count", C_RUN, 1'b0, 5, 1, 1'b0);
      hif.mem_br_taken = 1'b1; hif.mem_dREN = 1'b1;
      step("dstall_over_br", C_DST, 1'b0, 5, 1, 1'b0);
      hif.dhit = 1'b1;
      step("br_in_dstall", C_BR, 1'b0, 6, 1, 1'b0);

      setIdle();
      hif.mem_dREN = 1'b1; hif.mem_dWEN = 1'b1;
      for (int i = 0; i < 5; i++) step("dmiss", C_DST, 1'b0, 6 + i, 2, (i >= 4));
      hif.dhit = 1'b1;
      step("timeout_release", C_RUN, 1'b0, 11, 2, 1'b1);
      setIdle();
      step("timeout_sticky", C_RUN, 1'b0, 11, 2, 1'b1);

      hif.ihit = 1'b0;
      for (int i = 0; i < 6; i++)
         step("imiss_sat", C_IMISS, 1'b0, ((11 + i) > 15) ? 15 : (11 + i), 2, 1'b1);
      hif.ihit = 1'b1;
      step("sat_hold", C_RUN, 1'b0, 15, 2, 1'b1);

      hif.wb_halt = 1'b1;
      step("halt_cycle", C_RUN, 1'b0, 15, 2, 1'b1);
      hif.wb_halt = 1'b0;
      step("halted", C_ZERO, 1'b1, 15, 2, 1'b1);
      hif.ihit = 1'b0; hif.mem_dREN = 1'b1; hif.mem_br_taken = 1'b1;
      for (int i = 0; i < 3; i++) step("halted_hold", C_ZERO, 1'b1, 15, 2, 1'b1);

      setIdle();
      RST = 1'b1;
      step("rst_in_halt", C_ZERO, 1'b1, 15, 2, 1'b1);
      step("rst_clear", C_ZERO, 1'b0, 0, 0, 1'b0);
      RST = 1'b0;
      step("run_again", C_RUN, 1'b0, 0, 0, 1'b0);

      hif.mem_dREN = 1'b1; hif.wb_halt = 1'b1;
      step("halt_on_dstall", C_DST, 1'b0, 0, 0, 1'b0);
      hif.wb_halt = 1'b0; hif.dhit = 1'b1;
      step("halt_after_dstall", C_ZERO, 1'b1, 1, 0, 1'b0);

      RST = 1'b1;
      setIdle();
      step("rst2", C_ZERO, 1'b1, 1, 0, 1'b0);
      RST = 1'b0;
      hif.mem_dREN = 1'b1;
      step("stall_pre_rst", C_DST, 1'b0, 0, 0, 1'b0);
      RST = 1'b1;
      step("rst_mid_stall", C_ZERO, 1'b0, 1, 0, 1'b0);
      RST = 1'b0;
      step("stall_restart", C_DST, 1'b0, 0, 0, 1'b0);
      setIdle();
      step("run_final", C_RUN, 1'b0, 1, 0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
